// File: rtl/spi_pixel_receiver.sv
// -----------------------------------------------------------------------------
// spi_pixel_receiver
//
// Upstream stage of the HUB75 display controller. Deserialises 32-bit pixel
// words (MSB first, SPI mode 0) and issues single-cycle writes into the frame
// buffer. Each word {R, G, B, X} is packed to BITS_PER_PIXEL by keeping the
// top BITS_PER_RGB bits of every channel byte. Deasserting slave select ends
// the frame; frame_done pulses if exactly PIXELS words arrived.
//
// Optional feature (macro SPI_ECHO_EN): spi_miso echoes the previous complete
// word of the frame, MSB first, changing on spi_clk falling edges. Without
// the macro spi_miso is tied low.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   spi_clk    SPI clock (mode 0), asynchronous to clk
//   spi_mosi   SPI data in
//   spi_ss     slave select, active low
//   spi_miso   SPI data out (echo, or 0)
//   wr_en      one-cycle frame-buffer write strobe
//   wr_addr    write address (valid while wr_en=1)
//   wr_data    packed pixel
//   frame_done one-cycle pulse at the end of a complete frame
//   overrun    sticky: more than PIXELS words received in this frame
//   busy       high while receiving a frame
// -----------------------------------------------------------------------------
module spi_pixel_receiver #(
    parameter int BITS_PER_PIXEL = 16,
    parameter int PIXELS         = 2048,
    parameter int ADDR_WIDTH     = 11,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      spi_ss,
    output logic                      spi_miso,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [BITS_PER_PIXEL-1:0] wr_data,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      busy
);

    localparam int BITS_PER_RGB = BITS_PER_PIXEL / 4;
    localparam logic [ADDR_WIDTH:0] PIXELS_C = (ADDR_WIDTH + 1)'(PIXELS);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, ss_fall, ss_rise;

    logic [30:0]            shift_reg;   // bits already received of the current word
    logic [4:0]             bit_cnt;
    logic [ADDR_WIDTH:0]    pix_cnt;     // one extra bit so it can saturate at PIXELS
    logic                   wr_pend;

    logic [31:0]            new_word;
    logic                   word_complete, frame_full, write_ok;
    logic [ADDR_WIDTH:0]    count_after;

    function automatic logic [BITS_PER_PIXEL-1:0] pack_pixel(input logic [31:0] w);
        logic [BITS_PER_PIXEL-1:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            p[(4-i)*BITS_PER_RGB-1 -: BITS_PER_RGB] = w[31-8*i -: BITS_PER_RGB];
        return p;
    endfunction

    // Synchronisers plus one extra flop on clk/ss for edge detection.
    // Slave select resets to its inactive (high) level so no spurious
    // edge is seen when reset releases with the bus idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values and chains shift one stage.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    assign new_word      = {shift_reg, mosi_s};
    assign word_complete = (state_q == RECEIVE) && sclk_rise && (bit_cnt == 5'd31);
    assign frame_full    = (pix_cnt == PIXELS_C);
    assign write_ok      = word_complete && !frame_full;
    // Word count including a word completing in this very cycle, so an ss
    // rise coinciding with the 32nd edge sees the updated count.
    assign count_after   = pix_cnt + {{ADDR_WIDTH{1'b0}}, write_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = RECEIVE;
            RECEIVE: if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RECEIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            wr_pend    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // The word is captured on the cycle of the 32nd edge; the strobe
            // follows one cycle later, giving SYNC_STAGES+2 total latency.
            wr_en      <= wr_pend;
            wr_pend    <= 1'b0;
            frame_done <= 1'b0;
            if (state_q == IDLE) begin
                if (ss_fall) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    pix_cnt   <= '0;
                    overrun   <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    shift_reg <= new_word[30:0];
                    bit_cnt   <= bit_cnt + 5'd1;
                end
                if (word_complete) begin
                    if (!frame_full) begin
                        wr_pend <= 1'b1;
                        wr_addr <= pix_cnt[ADDR_WIDTH-1:0];
                        wr_data <= pack_pixel(new_word);
                        pix_cnt <= pix_cnt + 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                // A frame is complete only if no extra word arrived.
                if (ss_rise)
                    frame_done <= (count_after == PIXELS_C) && !overrun
                                  && !(word_complete && frame_full);
            end
        end
    end

`ifdef SPI_ECHO_EN
    logic        sclk_fall;
    logic [31:0] echo_word;
    logic        echo_valid;
    logic        miso_q;

    assign sclk_fall = ~sclk_s & sclk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_word  <= '0;
            echo_valid <= 1'b0;
            miso_q     <= 1'b0;
        end else if (state_q == IDLE) begin
            miso_q <= 1'b0;
            if (ss_fall) echo_valid <= 1'b0;
        end else begin
            if (word_complete) begin
                echo_word  <= new_word;
                echo_valid <= 1'b1;
            end
            // bit_cnt is the index of the next bit the master will sample,
            // so ~bit_cnt (= 31-bit_cnt) selects the matching echo bit.
            if (sclk_fall) miso_q <= echo_valid & echo_word[~bit_cnt];
            if (ss_rise)   miso_q <= 1'b0;
        end
    end

    assign spi_miso = miso_q;
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_pixel_receiver
//
// Self-checking bench for spi_pixel_receiver. An SPI master task drives words
// (4 clk per spi_clk phase); each complete word pushes its expected write into
// a scoreboard queue which a monitor pops and compares on every wr_en.
// A reduced frame size keeps the full-frame and overrun runs short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_pixel_receiver;

    localparam int BPP   = 16;
    localparam int PIX   = 16;
    localparam int AW    = 4;
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_ss = 1'b1;
    logic          spi_miso;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BPP-1:0] wr_data;
    logic          frame_done;
    logic          overrun;
    logic          busy;

    spi_pixel_receiver #(
        .BITS_PER_PIXEL(BPP),
        .PIXELS        (PIX),
        .ADDR_WIDTH    (AW),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_ss    (spi_ss),
        .spi_miso  (spi_miso),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [BPP-1:0] data;
        int             lsb_cyc;
    } wr_exp_t;

    wr_exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_count = 0;
    int fd_count = 0;

    // Bench model of the frame in progress.
    int m_words = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pack(input logic [31:0] w);
        return {w[31:28], w[23:20], w[15:12], w[7:4]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every write against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_count++;
            if (wr_en) begin
                wr_count++;
                if (sb.size() == 0) begin
                    check("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = sb.pop_front();
                    check("wr_addr",    32'(wr_addr), 32'(e.addr));
                    check("wr_data",    32'(wr_data), 32'(e.data));
                    check("wr_latency", 32'(cyc - e.lsb_cyc), 32'(SYNC + 2));
                end
            end
        end
    end

    task automatic ss_start();
        @(posedge clk); #2;
        spi_ss = 1'b0;
        m_words = 0;
        repeat (6) @(posedge clk);
    endtask

    task automatic ss_end();
        repeat (4) @(posedge clk); #2;
        spi_clk = 1'b0;
        repeat (4) @(posedge clk); #2;
        spi_ss = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of w MSB first; cap collects miso sampled just
    // before each rising edge (where a mode-0 master samples it).
    task automatic send_bits(input logic [31:0] w, input int n, output logic [31:0] cap);
        cap = '0;
        for (int k = 0; k < n; k++) begin
            repeat (4) @(posedge clk); #2;
            spi_clk  = 1'b0;
            spi_mosi = w[31-k];
            repeat (4) @(posedge clk); #2;
            cap[31-k] = spi_miso;
            spi_clk   = 1'b1;
            if (k == 31) begin
                if (m_words < PIX) begin
                    wr_exp_t e;
                    e.addr    = AW'(m_words);
                    e.data    = model_pack(w);
                    e.lsb_cyc = cyc;
                    sb.push_back(e);
                end
                m_words++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overrun"},    32'(overrun),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_miso"},       32'(spi_miso),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap, cap1, cap2;
        int wr_before, fd_before;

        // Reset values with no SPI activity.
        repeat (5) @(posedge clk);
        #1 check_reset_vals("rst");
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Single word: 0xFF804000 packs to 0xF840 at address 0.
        fd_before = fd_count;
        ss_start();
        check("busy_rx", 32'(busy), 32'd1);
        check("pack_const", 32'(model_pack(32'hFF80_4000)), 32'h0000_F840);
        send_bits(32'hFF80_4000, 32, cap);
        ss_end();
        check("single_busy_idle", 32'(busy), 32'd0);
        check("single_no_fd", 32'(fd_count - fd_before), 32'd0);
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Full frame: exactly PIX words -> one frame_done, no overrun.
        fd_before = fd_count;
        wr_before = wr_count;
        ss_start();
        for (int i = 0; i < PIX; i++)
            send_bits(32'(i) * 32'h0F1E_2D3C + 32'h0102_0304, 32, cap);
        ss_end();
        check("full_writes", 32'(wr_count - wr_before), 32'(PIX));
        check("full_fd", 32'(fd_count - fd_before), 32'd1);
        check("full_overrun", 32'(overrun), 32'd0);

        // Overrun: PIX+1 words -> last word not written, overrun, no frame_done.
        fd_before = fd_count;
        wr_before = wr_count;
        ss_start();
        for (int i = 0; i <= PIX; i++)
            send_bits(32'hA5C3_0000 ^ 32'(i * 32'h0101_1111), 32, cap);
        repeat (8) @(posedge clk);
        #1 check("ovr_set", 32'(overrun), 32'd1);
        ss_end();
        check("ovr_writes", 32'(wr_count - wr_before), 32'(PIX));
        check("ovr_no_fd", 32'(fd_count - fd_before), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // New frame clears overrun; a 17-bit partial word is discarded.
        ss_start();
        #1 check("ovr_clear", 32'(overrun), 32'd0);
        fd_before = fd_count;
        wr_before = wr_count;
        send_bits(32'hFFFF_FFFF, 17, cap);
        ss_end();
        check("partial_no_wr", 32'(wr_count - wr_before), 32'd0);
        check("partial_no_fd", 32'(fd_count - fd_before), 32'd0);

        // Reset mid-word, then a full word lands at address 0.
        ss_start();
        send_bits(32'hFFFF_FFFF, 20, cap);
        #1 reset = 1'b1;
        spi_ss  = 1'b1;
        spi_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("midrst");
        reset = 1'b0;
        repeat (5) @(posedge clk);
        wr_before = wr_count;
        ss_start();
        send_bits(32'h1234_5678, 32, cap);
        ss_end();
        check("rst_recover_wr", 32'(wr_count - wr_before), 32'd1);

        // Echo: second word carries the first on miso (when enabled).
        ss_start();
        send_bits(32'hDEAD_BEEF, 32, cap1);
        send_bits(32'h0000_0000, 32, cap2);
        ss_end();
        check("echo_word1", cap1, 32'h0);
`ifdef SPI_ECHO_EN
        check("echo_word2", cap2, 32'hDEAD_BEEF);
`else
        check("echo_word2", cap2, 32'h0);
`endif
        check("echo_idle_miso", 32'(spi_miso), 32'd0);

        repeat (10) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_pixel_receiver.md
Name: spi_pixel_receiver

Overview:
- Upstream stage of the HUB75 display controller. Deserialises pixel words arriving on an SPI slave interface and issues single-cycle writes into the frame buffer that the scan/refresh logic reads.
- Input words are 32 bits, MSB first. Each word is truncated to BITS_PER_PIXEL and written at an auto-incrementing address.
- The end of a frame is signalled when SS is deasserted, so the reader side can swap buffers.

Parameters:
- BITS_PER_PIXEL, 16, stored pixel width; multiple of 4 in range 4..32; BITS_PER_RGB = BITS_PER_PIXEL/4.
- PIXELS, 2048, pixels per frame (64x32 panel).
- ADDR_WIDTH, 11, frame-buffer address width; 2^ADDR_WIDTH >= PIXELS.
- SYNC_STAGES, 2, flip-flop synchroniser depth for spi_clk, spi_mosi and spi_ss.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_clk  in  1  SPI clock (mode 0: sample on rising edge); asynchronous to clk.
- spi_mosi  in  1  SPI data in.
- spi_ss  in  1  slave select, active-low.
- spi_miso  out  1  SPI data out (see Optional Feature).
- wr_en  out  1  one-cycle frame-buffer write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  BITS_PER_PIXEL  packed pixel.
- frame_done  out  1  one-cycle pulse at the end of a complete frame.
- overrun  out  1  sticky: more than PIXELS words were received in a frame.
- busy  out  1  high while in RECEIVE.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, overrun=0, busy=0, spi_miso=0, state=IDLE, bit counter=0, shift register=0.
- Synchronisation: all three SPI inputs pass through SYNC_STAGES flops. An extra flop on spi_clk and spi_ss provides edge detection. spi_clk high and low phases must each last at least 3 clk periods.
- Input word format: [31:24] R, [23:16] G, [15:8] B, [7:0] X (reserved).
- Packing: wr_data = {R[7 -: BITS_PER_RGB], G[7 -: BITS_PER_RGB], B[7 -: BITS_PER_RGB], X[7 -: BITS_PER_RGB]}, i.e. the top BITS_PER_RGB bits of each channel byte.
- FSM state IDLE: waits for a synchronised falling edge of ss, then clears the pixel address, bit counter and overrun, and moves to RECEIVE.
- FSM state RECEIVE, on each synchronised rising edge of spi_clk:
  - shift the synchronised mosi value into the LSB; bit counter +1 (5 bits, wraps 31->0).
  - on the edge completing bit 32: on the next clk, wr_en=1 for exactly one cycle, with wr_addr = the current pixel index and wr_data = the packed word; then the pixel index increments.
- FSM state RECEIVE, on a synchronised rising edge of ss: go to IDLE.
  - Any partial word (bit counter != 0) is discarded with no write.
  - frame_done pulses for 1 cycle if exactly PIXELS words were written in this frame; otherwise there is no pulse.
- Latency: a write strobe appears SYNC_STAGES+2 clk cycles after the spi_clk rising edge that carries bit 0 of the word (LSB).
- Full condition: once PIXELS words have been written, further complete words produce no wr_en and set overrun=1. overrun holds until the next ss falling edge or reset. The pixel index saturates at PIXELS; it does not wrap.
- Simultaneous events: if an ss rising edge and the 32nd spi_clk edge are detected in the same cycle, the word is written first, then the ss edge is handled in that same cycle's transition (frame_done evaluated with the updated count).
- spi_clk edges while in IDLE are ignored.
- Reset asserted mid-word or mid-frame: everything returns immediately to reset values; no write is issued for the partial word.
- wr_addr holds its last value between strobes; it is only meaningful while wr_en=1.

Optional Feature:
- Macro: SPI_ECHO_EN.
- Defined: spi_miso shifts out the previous complete 32-bit received word, MSB first.
  - One bit is presented per word bit, updated on the synchronised spi_clk falling edge.
  - The output is 0 during the first word of a frame and whenever ss is high.
- Not defined: spi_miso is tied to 0 and no echo register is synthesised.

Test Plan:
- Reset-value check: reset pulse with no SPI activity -> all outputs at their reset values; busy=0.
- Single-word capture: BITS_PER_PIXEL=16; ss low, then send 0xFF80_4000 -> one wr_en with wr_addr=0 and wr_data=0xF840; busy=1.
- Full frame: send 2048 words of value 0x0000_0000+index, then raise ss -> 2048 strobes with addresses 0..2047 and frame_done pulsed once; overrun=0.
- Overrun and partial word: send 2049 words -> no strobe for word 2049, overrun=1 and no frame_done. Then drop ss again -> overrun clears. Separately, raise ss after 17 bits -> no write.
- Asynchronous reset mid-word: assert reset after 20 bits, release, then send a full word -> the write lands at wr_addr=0 with the correct data.
- Echo (SPI_ECHO_EN defined): send 0xDEADBEEF then 0x00000000 -> miso carries 0xDEADBEEF MSB-first during the second word; with the macro undefined, miso stays 0.
